// File: rtl/counters_pkg.sv
// Shared types and encodings for the counters library.
package counters_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DN       = 1'b0;
    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/prescaler_tick.sv
// Prescaler: counts enabled cycles 0..presc and emits a one-cycle tick on compare.
module prescaler_tick #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] presc_i,
    output logic                  tick_o
);

    localparam logic [PRESCALE_W-1:0] PC_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pc_q, pc_d;

    // >= so that lowering presc below the current pc ticks immediately
    assign tick_o = advance_i && (pc_q >= presc_i);

    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (tick_o) begin
            pc_d = '0;
        end else if (advance_i) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with prescaled tick, load, one-shot mode and tc pulse.
module prog_mod_counter
    import counters_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] presc,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  running,
    output logic                  done
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             advance;
    logic             tick;
    logic             terminal;

    assign advance = (state_q == ST_RUN) && en;

    prescaler_tick #(
        .PRESCALE_W(PRESCALE_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .advance_i (advance),
        .clear_i   (load),
        .presc_i   (presc),
        .tick_o    (tick)
    );

    // Up uses >= so a limit lowered below the count still terminates on the next tick
    assign terminal = (dir == DIR_DN) ? (count_q == '0) : (count_q >= limit);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (tick) begin
            if (terminal) begin
                tc_d = 1'b1;
                if (dir == DIR_UP) begin
                    count_d = (mode == MODE_CONT) ? '0 : limit;
                end else begin
                    count_d = (mode == MODE_CONT) ? limit : '0;
                end
            end else if (dir == DIR_UP) begin
                count_d = count_q + CNT_ONE;
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = en ? ST_RUN : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (en) state_d = ST_RUN;
                ST_RUN: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (tick && terminal && (mode == MODE_ONESHOT)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        count   = count_q;
        tc      = tc_q;
        running = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed self-checking bench for prog_mod_counter: vector table plus corner-case sequences.
module tb_prog_mod_counter;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk;
    logic          rst;
    logic          en, dir, mode, load;
    logic [W-1:0]  load_val, limit, count;
    logic [PW-1:0] presc;
    logic          tc, running, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int en, dir, mode, load, load_val, limit, presc;
        int e_count, e_tc, e_run, e_done;
    } vec_t;

    vec_t tbl[$];

    prog_mod_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .presc    (presc),
        .count    (count),
        .tc       (tc),
        .running  (running),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input string fld, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    task automatic expect_out(input string nm, input int ec, input int etc, input int er, input int ed);
        check(nm, "count",   int'(count),   ec);
        check(nm, "tc",      int'(tc),      etc);
        check(nm, "running", int'(running), er);
        check(nm, "done",    int'(done),    ed);
    endtask

    task automatic drive(input int e, input int d, input int m, input int l,
                         input int lv, input int lim, input int p);
        en       = 1'(e);
        dir      = 1'(d);
        mode     = 1'(m);
        load     = 1'(l);
        load_val = W'(lv);
        limit    = W'(lim);
        presc    = PW'(p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int e, input int d, input int m, input int l, input int lv,
                       input int lim, input int p, input int ec, input int etc,
                       input int er, input int ed);
        vec_t v;
        v = '{e, d, m, l, lv, lim, p, ec, etc, er, ed};
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 1, 0, 0, 0, 4, 0);
        #2;
        expect_out("reset_init", 0, 0, 0, 0);
        #10;
        rst = 1'b1;

        // up, continuous, limit 4, every cycle
        add(1,1,0,0,0,4,0, 0,0,1,0);
        add(1,1,0,0,0,4,0, 1,0,1,0);
        add(1,1,0,0,0,4,0, 2,0,1,0);
        add(1,1,0,0,0,4,0, 3,0,1,0);
        add(1,1,0,0,0,4,0, 4,0,1,0);
        add(1,1,0,0,0,4,0, 0,1,1,0);
        add(1,1,0,0,0,4,0, 1,0,1,0);
        add(1,1,0,0,0,4,0, 2,0,1,0);
        add(0,1,0,0,0,4,0, 2,0,0,0);
        add(0,1,0,0,0,4,0, 2,0,0,0);
        // down, limit 3, tick every 3rd enabled cycle
        add(0,0,0,1,0,3,2, 0,0,0,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 3,1,1,0);
        add(1,0,0,0,0,3,2, 3,0,1,0);
        add(1,0,0,0,0,3,2, 3,0,1,0);
        add(1,0,0,0,0,3,2, 2,0,1,0);
        add(1,0,0,0,0,3,2, 2,0,1,0);
        add(1,0,0,0,0,3,2, 2,0,1,0);
        add(1,0,0,0,0,3,2, 1,0,1,0);
        add(1,0,0,0,0,3,2, 1,0,1,0);
        add(1,0,0,0,0,3,2, 1,0,1,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 0,0,1,0);
        add(1,0,0,0,0,3,2, 3,1,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].dir, tbl[i].mode, tbl[i].load,
                  tbl[i].load_val, tbl[i].limit, tbl[i].presc);
            step();
            expect_out($sformatf("tbl%0d", i), tbl[i].e_count, tbl[i].e_tc,
                       tbl[i].e_run, tbl[i].e_done);
        end

        // one-shot up to limit 2, then DONE ignores en and mode until a load
        drive(0, 1, 1, 1, 0, 2, 0); step(); expect_out("os_load",   0, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 2, 0); step(); expect_out("os_start",  0, 0, 1, 0);
        step();                             expect_out("os_c1",     1, 0, 1, 0);
        step();                             expect_out("os_c2",     2, 0, 1, 0);
        step();                             expect_out("os_term",   2, 1, 0, 1);
        step();                             expect_out("os_hold",   2, 0, 0, 1);
        drive(0, 1, 1, 0, 0, 2, 0); step(); expect_out("os_en0",    2, 0, 0, 1);
        drive(1, 1, 1, 0, 0, 2, 0); step(); expect_out("os_en1",    2, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 2, 0); step(); expect_out("os_mode0",  2, 0, 0, 1);
        drive(1, 1, 1, 1, 0, 2, 0); step(); expect_out("os_reload", 0, 0, 1, 0);
        drive(1, 1, 1, 0, 0, 2, 0); step(); expect_out("os_resume", 1, 0, 1, 0);

        // load coincident with a tick wins and restarts the prescaler
        drive(1, 1, 0, 1, 0, 6, 2); step(); expect_out("lvt_setup", 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 6, 2); step(); expect_out("lvt_pc1",   0, 0, 1, 0);
        step();                             expect_out("lvt_pc2",   0, 0, 1, 0);
        drive(1, 1, 0, 1, 9, 6, 2); step(); expect_out("lvt_load",  6, 0, 1, 0);
        drive(1, 1, 0, 0, 9, 6, 2); step(); expect_out("lvt_w1",    6, 0, 1, 0);
        step();                             expect_out("lvt_w2",    6, 0, 1, 0);
        step();                             expect_out("lvt_wrap",  0, 1, 1, 0);

        // limit lowered below the count while counting up
        drive(1, 1, 0, 1, 7, 10, 0); step(); expect_out("shr_load",  7, 0, 1, 0);
        drive(1, 1, 0, 0, 7, 3, 0);  step(); expect_out("shr_wrap",  0, 1, 1, 0);
        step();                              expect_out("shr_next",  1, 0, 1, 0);
        drive(0, 1, 0, 0, 7, 3, 0);  step(); expect_out("shr_stop",  1, 0, 0, 0);
        step();                              expect_out("shr_held",  1, 0, 0, 0);

        // limit 0: every tick terminal
        drive(1, 1, 0, 1, 5, 0, 0); step(); expect_out("lim0_load", 0, 0, 1, 0);
        drive(1, 1, 0, 0, 5, 0, 0); step(); expect_out("lim0_t1",   0, 1, 1, 0);
        step();                             expect_out("lim0_t2",   0, 1, 1, 0);

        // async reset mid-count with tc high
        drive(1, 0, 0, 1, 0, 5, 0); step(); expect_out("rst_setup", 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 5, 0); step(); expect_out("rst_pre",   5, 1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        step();
        expect_out("rst_after", 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
